// File: rtl/reset_boot_system.sv
// Boot reset sequencer: synchronizes the external reset release, then
// stages system reset and core reset deassertion from a counted delay.
module reset_boot_system #(
    parameter int unsigned CYCLES     = 20,
    parameter int unsigned CORE_DELAY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_rst_req_i,
    output logic rst_n_o,
    output logic rst_core_o,
    output logic boot_done_o
);

    localparam logic [1:0] S_HOLD      = 2'd0;
    localparam logic [1:0] S_COUNT     = 2'd1;
    localparam logic [1:0] S_CORE_WAIT = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam logic [15:0] CYC_LAST  = 16'(CYCLES - 1);
    localparam logic [7:0]  CORE_LAST =
        (CORE_DELAY == 0) ? 8'd0 : 8'(CORE_DELAY - 1);

    // Power-up values match HOLD so a boot sequence runs with rst_n tied high.
    logic [1:0]  sync_q     = 2'b00;
    logic [1:0]  state_q    = S_HOLD;
    logic [15:0] cyc_q      = 16'd0;
    logic [7:0]  core_q     = 8'd0;
    logic        rstn_q     = 1'b0;
    logic        core_rst_q = 1'b1;
    logic        boot_q     = 1'b0;

    logic [1:0]  state_d;
    logic [15:0] cyc_d;
    logic [7:0]  core_d;
    logic        rstn_d;
    logic        core_rst_d;
    logic        boot_d;
    logic        step;
    logic        restart;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        core_d     = core_q;
        rstn_d     = rstn_q;
        core_rst_d = core_rst_q;
        boot_d     = boot_q;
        step       = 1'b0;
        restart    = 1'b0;

        case (state_q)
            // The release edge itself is the first counted cycle.
            S_HOLD:      step = sync_q[1];
            S_COUNT: begin
                if (sw_rst_req_i) restart = 1'b1;
                else              step    = 1'b1;
            end
            S_CORE_WAIT: begin
                if (sw_rst_req_i) begin
                    restart = 1'b1;
                end else if (core_q == CORE_LAST) begin
                    core_d     = 8'd0;
                    core_rst_d = 1'b0;
                    boot_d     = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    core_d = core_q + 8'd1;
                end
            end
            S_RUN:       restart = sw_rst_req_i;
            default:     restart = 1'b1;
        endcase

        if (step) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d  = 16'd0;
                core_d = 8'd0;
                rstn_d = 1'b1;
                if (CORE_DELAY == 0) begin
                    core_rst_d = 1'b0;
                    boot_d     = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    state_d = S_CORE_WAIT;
                end
            end else begin
                cyc_d   = cyc_q + 16'd1;
                state_d = S_COUNT;
            end
        end

        if (restart) begin
            state_d    = S_COUNT;
            cyc_d      = 16'd0;
            core_d     = 8'd0;
            rstn_d     = 1'b0;
            core_rst_d = 1'b1;
            boot_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            state_q    <= S_HOLD;
            cyc_q      <= 16'd0;
            core_q     <= 8'd0;
            rstn_q     <= 1'b0;
            core_rst_q <= 1'b1;
            boot_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], 1'b1};
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            core_q     <= core_d;
            rstn_q     <= rstn_d;
            core_rst_q <= core_rst_d;
            boot_q     <= boot_d;
        end
    end

    assign rst_n_o     = rstn_q;
    assign rst_core_o  = core_rst_q;
    assign boot_done_o = boot_q;

endmodule

// File: tb/tb_reset_boot_system.sv
// Directed bench for reset_boot_system: default sizing plus a
// CYCLES=1 / CORE_DELAY=0 instance sharing clock and reset.
module tb_reset_boot_system;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sw    = 1'b0;
    logic sw2   = 1'b0;

    logic rst_n_o, rst_core_o, boot_done_o;
    logic rst_n_o2, rst_core_o2, boot_done_o2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_boot_system #(.CYCLES(20), .CORE_DELAY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req_i (sw),
        .rst_n_o      (rst_n_o),
        .rst_core_o   (rst_core_o),
        .boot_done_o  (boot_done_o)
    );

    reset_boot_system #(.CYCLES(1), .CORE_DELAY(0)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req_i (sw2),
        .rst_n_o      (rst_n_o2),
        .rst_core_o   (rst_core_o2),
        .boot_done_o  (boot_done_o2)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_rstn"}, rst_n_o, 1'b0);
        chk({tag, "_core"}, rst_core_o, 1'b1);
        chk({tag, "_boot"}, boot_done_o, 1'b0);
    endtask

    // Edge k is the k-th posedge after the reference point.
    task automatic track(input string tag, input int k0, input int n_rise,
                         input int n_fall, input int last);
        for (int k = k0; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == n_rise - 1 || k == n_rise)
                chk({tag, "_rstn"}, rst_n_o, k >= n_rise);
            if (k == n_fall - 1 || k == n_fall) begin
                chk({tag, "_core"}, rst_core_o, k < n_fall);
                chk({tag, "_boot"}, boot_done_o, k >= n_fall);
            end
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        chk_rst("pwrup0");
        track("pwrup", 1, 22, 26, 27);

        @(negedge clk);
        sw = 1'b1;
        @(posedge clk);
        #1;
        chk_rst("swp0");
        @(negedge clk);
        sw = 1'b0;
        track("swp", 1, 20, 24, 25);

        @(negedge clk);
        sw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k == 15 || k == 30)
                chk("swhold_rstn", rst_n_o, 1'b0);
        end
        @(negedge clk);
        sw = 1'b0;
        track("swhold", 1, 20, 24, 25);

        pulse_reset(3);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (k >= 2) begin
                chk("d2_rstn", rst_n_o2, k >= 3);
                chk("d2_core", rst_core_o2, k < 3);
                chk("d2_boot", boot_done_o2, k >= 3);
            end
        end
        track("pulse", 4, 22, 26, 27);

        pulse_reset(2);
        track("midcnt_pre", 1, 22, 26, 12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst("midcnt_async");
        @(negedge clk);
        rst_n = 1'b1;
        track("midcnt", 1, 22, 26, 27);

        pulse_reset(2);
        track("midcw_pre", 1, 22, 26, 23);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst("midcw_async");
        @(negedge clk);
        rst_n = 1'b1;
        track("midcw", 1, 22, 26, 27);

        @(negedge clk);
        rst_n = 1'b0;
        sw    = 1'b1;
        #1;
        chk_rst("run_async_sw");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sw_rstn", rst_n_o, 1'b0);
        @(negedge clk);
        sw = 1'b0;
        track("hold_sw", 4, 22, 26, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_boot_system.md
RESET_BOOT_SYSTEM -- requirements
Module: reset_boot_system

Interface
REQ-001 Parameter CYCLES, default 20, SHALL set the number of clock cycles rst_n_o is held low after the synchronized reset release; legal range 1..65535.
REQ-002 Parameter CORE_DELAY, default 4, SHALL set the number of additional cycles rst_core_o stays high after rst_n_o rises; legal range 0..255.
REQ-003 clk  input  1  SHALL be the single clock; all state is clocked on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low external reset; tie high when unused.
REQ-005 sw_rst_req_i  input  1  SHALL be a synchronous, active-high request to re-run the boot reset sequence.
REQ-006 rst_n_o  output  1  SHALL be the active-low system reset, registered.
REQ-007 rst_core_o  output  1  SHALL be the active-high core reset, registered.
REQ-008 boot_done_o  output  1  SHALL be high only in state RUN.

Function
REQ-009 State machine SHALL have states HOLD, COUNT, CORE_WAIT and RUN.
REQ-010 rst_n low SHALL asynchronously force state HOLD, counters 0, synchronizer 0, rst_n_o=0, rst_core_o=1 and boot_done_o=0.
REQ-011 Release of rst_n SHALL pass through a 2-flop synchronizer clocked by clk with async clear from rst_n; this synchronizer is the only path from rst_n into the state machine.
REQ-012 HOLD SHALL go to COUNT on the first edge where the synchronized release is 1, with the counter cleared.
REQ-013 COUNT SHALL increment the counter each cycle; on the edge where the counter equals CYCLES-1, it SHALL set rst_n_o=1, clear the counter, and go to CORE_WAIT, or to RUN if CORE_DELAY=0.
REQ-014 rst_n_o SHALL therefore rise exactly CYCLES+2 rising edges after rst_n rises, counting 2 synchronizer edges.
REQ-015 CORE_WAIT SHALL count CORE_DELAY cycles; on the final edge it SHALL set rst_core_o=0 and boot_done_o=1 and go to RUN.
REQ-016 With CORE_DELAY=0, rst_core_o SHALL fall on the same edge that rst_n_o rises.
REQ-017 RUN SHALL hold rst_n_o=1, rst_core_o=0 and boot_done_o=1 until a reset event.
REQ-018 sw_rst_req_i sampled high in COUNT, CORE_WAIT or RUN SHALL, on that edge, set rst_n_o=0, rst_core_o=1 and boot_done_o=0, clear the counters, and go to COUNT, restarting the full CYCLES count.
REQ-019 sw_rst_req_i in HOLD SHALL be ignored.
REQ-020 sw_rst_req_i held high continuously SHALL keep the block in COUNT with rst_n_o low.
REQ-021 Counter widths SHALL be 16 bits for CYCLES and 8 bits for CORE_DELAY; counters SHALL never wrap because they are cleared on terminal count.
REQ-022 rst_n assertion at any time, including mid-COUNT or mid-CORE_WAIT, SHALL override everything per REQ-010.
REQ-023 rst_n assertion and a simultaneous sw_rst_req_i SHALL resolve in favour of rst_n.
REQ-024 Outputs SHALL be glitch-free register outputs with no combinational path from any input.

Reset
REQ-025 All registers SHALL also carry power-up initial values equal to the HOLD-state values, so a boot reset sequence runs after configuration even with rst_n tied high.
REQ-026 The reset values SHALL be: state HOLD, counters 0, synchronizer 00, rst_n_o=0, rst_core_o=1, boot_done_o=0.

Verification (CYCLES=20, CORE_DELAY=4)
REQ-027 Pulse rst_n low for 3 cycles, then release -> rst_n_o rises on the 22nd edge after release, rst_core_o falls 4 edges later, and boot_done_o=1 at the same time.
REQ-028 Power-up with rst_n tied high -> same timing measured from the first clock edge, with rst_n_o=0 before that point.
REQ-029 In RUN, pulse sw_rst_req_i for 1 cycle -> rst_n_o=0 and rst_core_o=1 on that edge, rst_n_o rises 20 edges later, and rst_core_o falls 4 edges after that.
REQ-030 Assert rst_n mid-COUNT (counter=10) -> outputs go to reset values immediately without waiting for a clock edge; after release, the full 22-edge sequence repeats.
REQ-031 CORE_DELAY=0, CYCLES=1 -> rst_n_o rises and rst_core_o falls on the same edge, 3 edges after rst_n release.
REQ-032 sw_rst_req_i held high for 30 cycles -> rst_n_o stays low throughout and rises 20 edges after the request drops.
